// File: rtl/fetch_npc_gen.sv
// Fetch-stage next-PC generator with Alpha control-flow predecode.
// Holds the fetch PC, picks the 32-bit word out of the I-cache line,
// predicts the next PC (BR/BSR target, RAS return, or PC+4), drives the
// return address stack strobes and loads the IF/ID pipeline register.
module fetch_npc_gen #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          DROP_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [63:0]           Icache_data,
  input  logic                  Icache_valid,
  output logic [63:0]           proc2Icache_addr,
  input  logic                  if_stall,
  input  logic                  redirect_en,
  input  logic [63:0]           redirect_PC,
  input  logic [63:0]           ret_NPC,
  input  logic                  ras_busy,
  output logic                  is_call,
  output logic                  is_ret,
  output logic [63:0]           call_NPC,
  output logic                  if_valid,
  output logic [31:0]           if_IR,
  output logic [63:0]           if_PC,
  output logic [63:0]           if_NPC,
  output logic                  if_pred_taken,
  output logic [DROP_CNT_W-1:0] ras_drop_cnt
);

  typedef enum logic [1:0] {FETCH, REDIRECT, HALTED} state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic        ras_full_q;

  logic [31:0] word;
  logic [5:0]  opcode;
  logic [1:0]  func;
  logic        op_br, op_bsr, op_jgrp, op_ret, op_call, op_halt;
  logic [63:0] pc_plus4, br_target, npc;
  logic        fire, pred_taken, drop_inc;

  assign proc2Icache_addr = {pc[63:3], 3'b000};

  // Predecode of the word selected by PC[2]
  assign word     = pc[2] ? Icache_data[63:32] : Icache_data[31:0];
  assign opcode   = word[31:26];
  assign func     = word[15:14];
  assign op_br    = (opcode == 6'h30);
  assign op_bsr   = (opcode == 6'h34);
  assign op_jgrp  = (opcode == 6'h1A);
  assign op_ret   = op_jgrp && (func == 2'b10);
  assign op_call  = op_bsr || (op_jgrp && func[0]);
  assign op_halt  = (word == 32'h0);

  assign pc_plus4  = pc + 64'd4;
  assign br_target = pc_plus4 + {{41{word[20]}}, word[20:0], 2'b00};

  // A fetch is accepted only when nothing higher priority is happening;
  // reset is folded in so strobes stay quiet while reset is held.
  assign fire = reset && (state == FETCH) && Icache_valid && !if_stall && !redirect_en;

  // Predicted next PC: branch target, RAS top for returns, else fall-through
  always_comb begin
    npc = pc_plus4;
    if (op_br || op_bsr) begin
      npc = br_target;
    end else if (op_ret) begin
      npc = ret_NPC;
    end
  end

  assign pred_taken = (npc != pc_plus4);

  // The RAS is only pushed when it was not full last cycle; ras_busy is
  // deliberately not used combinationally here.
  assign is_call  = fire && op_call && !ras_full_q;
  assign is_ret   = fire && op_ret;
  assign call_NPC = pc_plus4;
  assign drop_inc = fire && op_call && ras_full_q;

  // Next state and next fetch PC; redirect wins in every state
  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (redirect_en) begin
      state_next = REDIRECT;
      pc_next    = redirect_PC;
    end else begin
      case (state)
        FETCH: begin
          if (fire) begin
            if (op_halt) begin
              state_next = HALTED;
            end else begin
              pc_next = npc;
            end
          end
        end
        REDIRECT: state_next = FETCH;
        HALTED:   state_next = HALTED;
        default:  state_next = FETCH;
      endcase
    end
  end

  // State and PC registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // RAS-full sample and saturating count of calls that could not be pushed
  always_ff @(posedge clock) begin
    if (!reset) begin
      ras_full_q   <= 1'b0;
      ras_drop_cnt <= '0;
    end else begin
      ras_full_q <= ras_busy;
      if (drop_inc && !(&ras_drop_cnt)) begin
        ras_drop_cnt <= ras_drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // IF/ID register: redirect kills, fire loads, stall holds, else bubble
  always_ff @(posedge clock) begin
    if (!reset) begin
      if_valid      <= 1'b0;
      if_IR         <= 32'h0;
      if_PC         <= 64'h0;
      if_NPC        <= 64'h0;
      if_pred_taken <= 1'b0;
    end else if (redirect_en) begin
      if_valid <= 1'b0;
    end else if (fire) begin
      if_valid      <= 1'b1;
      if_IR         <= word;
      if_PC         <= pc;
      if_NPC        <= npc;
      if_pred_taken <= pred_taken;
    end else if (!if_stall) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_npc_gen.sv
// Self-checking bench for fetch_npc_gen: directed scenarios followed by a
// randomized phase, all compared against an instruction-level reference model.
module tb_fetch_npc_gen;

  localparam int MODE_FETCH    = 0;
  localparam int MODE_REDIRECT = 1;
  localparam int MODE_HALTED   = 2;

  localparam logic [31:0] W_ADDQ = 32'h40220403;
  localparam logic [31:0] W_BSR  = 32'hD3400010;
  localparam logic [31:0] W_RET  = 32'h6BFA8000;
  localparam logic [31:0] W_JSR  = 32'h6BFA4000;
  localparam logic [31:0] W_BR_M1 = 32'hC01FFFFF;
  localparam logic [31:0] W_HALT = 32'h00000000;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] Icache_data;
  logic        Icache_valid;
  logic [63:0] proc2Icache_addr;
  logic        if_stall;
  logic        redirect_en;
  logic [63:0] redirect_PC;
  logic [63:0] ret_NPC;
  logic        ras_busy;
  logic        is_call;
  logic        is_ret;
  logic [63:0] call_NPC;
  logic        if_valid;
  logic [31:0] if_IR;
  logic [63:0] if_PC;
  logic [63:0] if_NPC;
  logic        if_pred_taken;
  logic [7:0]  ras_drop_cnt;

  int checks = 0;
  int errors = 0;
  int call_pulses = 0;

  // Reference model state
  logic [63:0] m_pc;
  int          m_mode;
  bit          m_full;
  int          m_drop;
  bit          m_valid;
  logic [31:0] m_ir;
  logic [63:0] m_ipc;
  logic [63:0] m_npc;
  bit          m_taken;

  always #5 clock = ~clock;

  fetch_npc_gen #(.RESET_PC(64'h0), .DROP_CNT_W(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .Icache_data     (Icache_data),
    .Icache_valid    (Icache_valid),
    .proc2Icache_addr(proc2Icache_addr),
    .if_stall        (if_stall),
    .redirect_en     (redirect_en),
    .redirect_PC     (redirect_PC),
    .ret_NPC         (ret_NPC),
    .ras_busy        (ras_busy),
    .is_call         (is_call),
    .is_ret          (is_ret),
    .call_NPC        (call_NPC),
    .if_valid        (if_valid),
    .if_IR           (if_IR),
    .if_PC           (if_PC),
    .if_NPC          (if_NPC),
    .if_pred_taken   (if_pred_taken),
    .ras_drop_cnt    (ras_drop_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch target as plain signed arithmetic on the 21-bit displacement
  function automatic logic [63:0] branchTarget(input logic [63:0] pc, input logic [31:0] w);
    longint d;
    d = longint'(w[20:0]);
    if (d >= 1048576) d = d - 2097152;
    return pc + 64'd4 + 64'(d * 4);
  endfunction

  function automatic logic [31:0] randomWord();
    case ($urandom_range(0, 9))
      0: return {6'h30, 5'($urandom), 21'($urandom)};
      1: return {6'h34, 5'($urandom), 21'($urandom)};
      2, 3: return {6'h1A, 10'($urandom), 2'($urandom), 14'($urandom)};
      4: return {6'(6'h38 + 6'($urandom_range(0, 7))), 26'($urandom)};
      5: return ($urandom_range(0, 3) == 0) ? W_HALT : W_ADDQ;
      6: return $urandom;
      default: return {6'h10, 26'($urandom)};
    endcase
  endfunction

  task automatic modelReset();
    m_pc = 64'h0; m_mode = MODE_FETCH; m_full = 0; m_drop = 0;
    m_valid = 0; m_ir = 32'h0; m_ipc = 64'h0; m_npc = 64'h0; m_taken = 0;
  endtask

  // One clock cycle: drive inputs, check strobes mid-cycle, advance model, check registers
  task automatic applyStimulus(input bit rst_n, input bit ival, input bit stall, input bit redir,
                               input logic [63:0] rpc, input logic [31:0] w,
                               input logic [63:0] rnpc, input bit busy);
    int          op, fn;
    bit          brk, callk, retk, haltk, fire;
    logic [63:0] npc;
    @(negedge clock);
    reset        = rst_n;
    Icache_valid = ival;
    if_stall     = stall;
    redirect_en  = redir;
    redirect_PC  = rpc;
    ret_NPC      = rnpc;
    ras_busy     = busy;
    Icache_data  = m_pc[2] ? {w, 32'($urandom)} : {32'($urandom), w};
    #1;
    op    = int'(w[31:26]);
    fn    = int'(w[15:14]);
    brk   = (op == 48) || (op == 52);
    callk = (op == 52) || (op == 26 && (fn == 1 || fn == 3));
    retk  = (op == 26) && (fn == 2);
    haltk = (w == 32'h0);
    fire  = rst_n && (m_mode == MODE_FETCH) && ival && !stall && !redir;
    npc   = brk ? branchTarget(m_pc, w) : (retk ? rnpc : m_pc + 64'd4);
    checkOutput("icache_addr", proc2Icache_addr, m_pc & ~64'h7);
    checkOutput("is_call", {63'h0, is_call}, {63'h0, fire && callk && !m_full});
    checkOutput("is_ret", {63'h0, is_ret}, {63'h0, fire && retk});
    if (fire) checkOutput("call_npc", call_NPC, m_pc + 64'd4);
    if (is_call) call_pulses++;
    @(posedge clock);
    if (!rst_n) begin
      modelReset();
    end else begin
      if (redir) m_valid = 0;
      else if (fire) begin
        m_valid = 1; m_ir = w; m_ipc = m_pc; m_npc = npc; m_taken = (npc != m_pc + 64'd4);
      end else if (!stall) m_valid = 0;
      if (fire && callk && m_full && m_drop < 255) m_drop++;
      m_full = busy;
      if (redir) begin
        m_mode = MODE_REDIRECT; m_pc = rpc;
      end else if (m_mode == MODE_REDIRECT) begin
        m_mode = MODE_FETCH;
      end else if (fire) begin
        if (haltk) m_mode = MODE_HALTED;
        else m_pc = npc;
      end
    end
    #1;
    checkOutput("if_valid", {63'h0, if_valid}, {63'h0, m_valid});
    checkOutput("if_ir", {32'h0, if_IR}, {32'h0, m_ir});
    checkOutput("if_pc", if_PC, m_ipc);
    checkOutput("if_npc", if_NPC, m_npc);
    checkOutput("if_pred_taken", {63'h0, if_pred_taken}, {63'h0, m_taken});
    checkOutput("ras_drop_cnt", {56'h0, ras_drop_cnt}, 64'(m_drop));
  endtask

  // Shorthands for the directed scenarios
  task automatic fetchWord(input logic [31:0] w, input logic [63:0] rnpc);
    applyStimulus(1, 1, 0, 0, 64'h0, w, rnpc, 0);
  endtask

  task automatic redirectTo(input logic [63:0] target);
    applyStimulus(1, 1, 0, 1, target, W_ADDQ, 64'h0, 0);
    applyStimulus(1, 1, 0, 0, 64'h0, W_BSR, 64'h0, 0);
  endtask

  initial begin
    reset = 1'b0; Icache_valid = 1'b0; if_stall = 1'b0; redirect_en = 1'b0;
    redirect_PC = 64'h0; ret_NPC = 64'h0; ras_busy = 1'b0; Icache_data = 64'h0;
    modelReset();
    @(posedge clock);

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 0, 64'h0, W_ADDQ, 64'h0, 0);
    applyStimulus(0, 0, 0, 0, 64'h0, W_ADDQ, 64'h0, 0);
    checkOutput("reset_addr", proc2Icache_addr, 64'h0);
    checkOutput("reset_valid", {63'h0, if_valid}, 64'h0);

    $display("[TB] straight-line");
    redirectTo(64'h100);
    fetchWord(W_ADDQ, 64'h0);
    checkOutput("addq0_pc", if_PC, 64'h100);
    checkOutput("addq0_npc", if_NPC, 64'h104);
    fetchWord(W_ADDQ, 64'h0);
    checkOutput("addq1_pc", if_PC, 64'h104);
    checkOutput("addq1_taken", {63'h0, if_pred_taken}, 64'h0);

    $display("[TB] bsr/ret/br");
    redirectTo(64'h200);
    fetchWord(W_BSR, 64'h0);
    checkOutput("bsr_npc", if_NPC, 64'h244);
    fetchWord(W_RET, 64'h204);
    checkOutput("ret_npc", if_NPC, 64'h204);
    fetchWord(W_ADDQ, 64'h0);
    checkOutput("after_ret_pc", if_PC, 64'h204);
    redirectTo(64'h300);
    fetchWord(W_BR_M1, 64'h0);
    checkOutput("br_npc", if_NPC, 64'h300);
    checkOutput("br_taken", {63'h0, if_pred_taken}, 64'h1);

    $display("[TB] stall");
    redirectTo(64'h400);
    fetchWord(W_ADDQ, 64'h0);
    call_pulses = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 64'h0, W_BSR, 64'h0, 0);
    checkOutput("stall_hold_pc", if_PC, 64'h400);
    fetchWord(W_BSR, 64'h0);
    checkOutput("stall_call_pulses", 64'(call_pulses), 64'd1);

    $display("[TB] ras full");
    applyStimulus(1, 0, 0, 0, 64'h0, W_JSR, 64'h0, 1);
    applyStimulus(1, 1, 0, 0, 64'h0, W_JSR, 64'h0, 1);
    checkOutput("drop_one", {56'h0, ras_drop_cnt}, 64'd1);
    for (int i = 0; i < 300; i++) applyStimulus(1, 1, 0, 0, 64'h0, W_JSR, 64'h0, 1);
    checkOutput("drop_sat", {56'h0, ras_drop_cnt}, 64'd255);
    applyStimulus(1, 0, 0, 0, 64'h0, W_ADDQ, 64'h0, 0);

    $display("[TB] redirect vs fire, halt");
    call_pulses = 0;
    applyStimulus(1, 1, 0, 1, 64'h800, W_BSR, 64'h0, 0);
    checkOutput("redir_no_call", 64'(call_pulses), 64'd0);
    checkOutput("redir_kill", {63'h0, if_valid}, 64'h0);
    applyStimulus(1, 1, 0, 0, 64'h0, W_ADDQ, 64'h0, 0);
    fetchWord(W_ADDQ, 64'h0);
    checkOutput("redir_first_pc", if_PC, 64'h800);
    fetchWord(W_HALT, 64'h0);
    checkOutput("halt_ir", {32'h0, if_IR}, 64'h0);
    for (int i = 0; i < 3; i++) fetchWord(W_ADDQ, 64'h0);
    checkOutput("halted_valid", {63'h0, if_valid}, 64'h0);
    checkOutput("halted_addr", proc2Icache_addr, 64'h800);
    redirectTo(64'h900);
    fetchWord(W_ADDQ, 64'h0);
    checkOutput("unhalt_pc", if_PC, 64'h900);

    $display("[TB] reset overrides redirect");
    applyStimulus(0, 1, 0, 1, 64'hA00, W_ADDQ, 64'h0, 1);
    checkOutput("midreset_addr", proc2Icache_addr, 64'h0);

    $display("[TB] random");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 19) == 0),
                    {$urandom, $urandom} & ~64'h3,
                    randomWord(),
                    {$urandom, $urandom} & ~64'h3,
                    ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_npc_gen.md
# fetch_npc_gen

Fetch-stage next-PC generator and predecoder. It holds the fetch PC, selects the 32-bit instruction from the I-cache line, and predecodes Alpha control flow (BR/BSR/JSR/RET/JMP/HALT). It drives the return address stack (`is_call`, `is_ret`, `call_NPC`) and consumes its `ret_NPC`/`ras_busy`. It latches the fetched instruction plus its predicted next PC into the IF/ID register and applies redirects from execute/retire.

## Interface
Parameters:
- `RESET_PC`, 64'h0, fetch PC after reset.
- `DROP_CNT_W`, 8, width of the saturating dropped-call counter.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low (state cleared on posedge while `reset`==0).
- `Icache_data`  in  64  line at `proc2Icache_addr`; word = PC[2] ? [63:32] : [31:0].
- `Icache_valid`  in  1  `Icache_data` valid this cycle.
- `proc2Icache_addr`  out  64  {PC[63:3],3'b0}.
- `if_stall`  in  1  IF/ID consumer cannot accept.
- `redirect_en`  in  1  misprediction/exception redirect.
- `redirect_PC`  in  64  redirect target.
- `ret_NPC`  in  64  RAS top, valid in the cycle `is_ret`=1.
- `ras_busy`  in  1  RAS at last entry.
- `is_call`, `is_ret`  out  1  RAS push/pop strobes.
- `call_NPC`  out  64  PC+4 of the call.
- `if_valid`  out  1  IF/ID entry valid.
- `if_IR`  out  32  instruction.
- `if_PC`, `if_NPC`  out  64  instruction PC; predicted next PC.
- `if_pred_taken`  out  1  prediction deviates from PC+4.
- `ras_drop_cnt`  out  DROP_CNT_W  calls not pushed, saturating.

## Operation
- States: FETCH, REDIRECT, HALTED. Reset → FETCH, PC=`RESET_PC`, every output register 0, `ras_full_q`=0.
- `fire` = state==FETCH && `Icache_valid` && !`if_stall` && !`redirect_en`.
- Predecode of the selected word: opcode=[31:26]. BR 0x30, BSR 0x34: target = PC+4+(sext(disp[20:0])<<2), mod 2^64. Conditional 0x38–0x3F predict not-taken. Opcode 0x1A uses func [15:14]: 00 JMP, 01 JSR, 10 RET, 11 JSR_CO. HALT = word 32'h0.
- On `fire`, predicted NPC:
  - BR/BSR → target.
  - RET → `ret_NPC`.
  - JMP/JSR/JSR_CO → PC+4; execute resolves through a redirect.
  - All others → PC+4.
  - PC←NPC. `if_pred_taken`=1 exactly when NPC≠PC+4.
- RAS strobes are combinational, qualified by `fire`:
  - `is_call` = BSR|JSR|JSR_CO, and only while `ras_full_q`=0.
  - `is_ret` = RET.
  - JSR_CO asserts `is_call` only, not `is_ret`.
  - `call_NPC`=PC+4.
- `ras_busy` never feeds `is_call` combinationally. It is registered into `ras_full_q` every cycle. A call fired while `ras_full_q`=1 is fetched normally with no push, and `ras_drop_cnt` increments, saturating at all-ones.
- IF/ID register update, per cycle:
  - `redirect_en`: `if_valid`←0.
  - Otherwise `fire`: load IR, PC, NPC, pred_taken, and `if_valid`←1.
  - Otherwise `if_stall`: hold all IF/ID fields.
  - Otherwise: `if_valid`←0.
- Transitions (`redirect_en` has top priority in every state):
  - `redirect_en`: PC←`redirect_PC`, state→REDIRECT, RAS strobes 0.
  - REDIRECT→FETCH unconditionally after one cycle, with no fire.
  - FETCH: firing HALT→HALTED. HALT is passed to IF/ID and PC is not advanced.
  - HALTED holds until `redirect_en`.
- The RAS is not flushed on redirect. Mispredicted returns recover through later redirects.

## Timing
- `proc2Icache_addr` reflects the PC register.
- `fire` in cycle N → IF/ID valid and PC updated at edge N+1; the next fetch may fire in cycle N+1 (1 instruction/cycle).
- Redirect in cycle N: `if_valid`=0 after edge N+1, cycle N+1 is REDIRECT, first possible fire is cycle N+2 at `redirect_PC`.
- `Icache_valid`=0 inserts a bubble; PC is held.
- `if_stall` holds PC and IF/ID indefinitely; no RAS strobe while stalled.
- Reset mid-operation overrides redirect, fire and stall in the same cycle.

## Test plan
- Reset with `reset`=0 for 2 cycles → `proc2Icache_addr`=0, `if_valid`=0, `is_call`=`is_ret`=0, `ras_drop_cnt`=0.
- Straight-line ADDQ at PC 0x100 and 0x104, `Icache_valid`=1 → `if_PC`=0x100 then 0x104, `if_NPC`=PC+4, `if_pred_taken`=0.
- BSR disp=0x10 at 0x200 → `is_call`=1, `call_NPC`=0x204, `if_NPC`=0x244. RET at 0x244 with `ret_NPC`=0x204 → `is_ret`=1, next fetch PC 0x204. BR disp=-1 at 0x300 → target 0x300.
- `if_stall`=1 for 3 cycles while a BSR is presented → `is_call` stays 0 and IF/ID holds. After release: exactly one `is_call` pulse.
- `ras_busy`=1 one cycle before a JSR fires → no push, `ras_drop_cnt`=1. Drive 300 such calls → count saturates at 255.
- `redirect_en`=1, `redirect_PC`=0x800 simultaneous with `fire` of a BSR → no `is_call`, `if_valid`=0 next cycle, first fetch at 0x800 two cycles later. HALT word → HALTED, no further fires until a redirect.
